// File: rtl/bit_4_add_sub_pkg.sv
// rtl/bit_4_add_sub_pkg.sv - shared mode encoding for the 4-bit adder/subtractor
package bit_4_add_sub_pkg;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

endpackage

// File: rtl/bit_4_add_sub_full_adder.sv
// rtl/bit_4_add_sub_full_adder.sv - one-bit full adder cell for the ripple chain
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/bit_4_add_sub.sv
// rtl/bit_4_add_sub.sv - registered two's-complement adder/subtractor with carry and overflow
module bit_4_add_sub
  import bit_4_add_sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             M,
  output logic [WIDTH-1:0] S,
  output logic             C,
  output logic             V
);

  mode_e            mode;
  logic             sub_en;
  logic [WIDTH-1:0] b_x;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   carry;

  logic [WIDTH-1:0] s_d, s_q;
  logic             c_d, c_q;
  logic             v_d, v_q;

  assign mode   = mode_e'(M);
  assign sub_en = (mode == MODE_SUB);

  // Subtraction is A + ~B + 1: invert B and inject the +1 as carry-in.
  assign b_x      = B ^ {WIDTH{sub_en}};
  assign carry[0] = sub_en;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    full_adder u_fa (
      .a    (A[i]),
      .b    (b_x[i]),
      .cin  (carry[i]),
      .s    (sum[i]),
      .cout (carry[i+1])
    );
  end

  always_comb begin
    s_d = sum;
    c_d = carry[WIDTH];
    v_d = carry[WIDTH] ^ carry[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q <= '0;
      c_q <= 1'b0;
      v_q <= 1'b0;
    end else begin
      s_q <= s_d;
      c_q <= c_d;
      v_q <= v_d;
    end
  end

  assign S = s_q;
  assign C = c_q;
  assign V = v_q;

endmodule

// File: tb/tb_bit_4_add_sub.sv
// tb/tb_bit_4_add_sub.sv - directed and exhaustive self-checking bench for bit_4_add_sub
module tb_bit_4_add_sub;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] A, B;
  logic       M;
  logic [3:0] S;
  logic       C, V;

  int n_cmp = 0;
  int n_err = 0;

  bit_4_add_sub #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .A   (A),
    .B   (B),
    .M   (M),
    .S   (S),
    .C   (C),
    .V   (V)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got S=%0d C=%0b V=%0b, expected S=%0d C=%0b V=%0b",
               tag, got[5:2], got[1], got[0], exp[5:2], exp[1], exp[0]);
    end
  endtask

  // Drive on the falling edge, let one rising edge capture, sample 1 time unit later.
  task automatic step(input logic [3:0] a, input logic [3:0] b, input logic m, input logic r);
    @(negedge clk);
    A = a; B = b; M = m; rst = r;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] model(input logic [3:0] a, input logic [3:0] b, input logic m);
    int         full;
    logic [3:0] s;
    logic       v;
    full = int'(a) + (m ? int'(4'(~b)) : int'(b)) + int'(m);
    s    = full[3:0];
    if (m) v = (a[3] != b[3]) && (s[3] != a[3]);
    else   v = (a[3] == b[3]) && (s[3] != a[3]);
    return {s, full[4], v};
  endfunction

  initial begin
    rst = 1'b1; A = '0; B = '0; M = 1'b0;

    step(4'd9, 4'd3, 1'b1, 1'b1);
    check("reset", {S, C, V}, {4'd0, 1'b0, 1'b0});
    step(4'd0, 4'd5, 1'b0, 1'b0);
    check("post_reset_0p5", {S, C, V}, {4'd5, 1'b0, 1'b0});

    step(4'd5, 4'd5, 1'b0, 1'b0);
    check("add_5p5_ovf", {S, C, V}, {4'd10, 1'b0, 1'b1});
    step(4'd15, 4'd1, 1'b0, 1'b0);
    check("add_15p1_wrap", {S, C, V}, {4'd0, 1'b1, 1'b0});

    step(4'd5, 4'd10, 1'b1, 1'b0);
    check("sub_5m10", {S, C, V}, {4'd11, 1'b0, 1'b1});
    step(4'd10, 4'd10, 1'b1, 1'b0);
    check("sub_10m10", {S, C, V}, {4'd0, 1'b1, 1'b0});
    step(4'd0, 4'd0, 1'b1, 1'b0);
    check("sub_0m0", {S, C, V}, {4'd0, 1'b1, 1'b0});
    step(4'd8, 4'd1, 1'b1, 1'b0);
    check("sub_8m1_ovf", {S, C, V}, {4'd7, 1'b1, 1'b1});
    step(4'd7, 4'd15, 1'b1, 1'b0);
    check("sub_7m15_ovf", {S, C, V}, {4'd8, 1'b0, 1'b1});

    step(4'd3, 4'd2, 1'b0, 1'b0);
    check("toggle_add", {S, C, V}, {4'd5, 1'b0, 1'b0});
    step(4'd3, 4'd2, 1'b1, 1'b0);
    check("toggle_sub", {S, C, V}, {4'd1, 1'b1, 1'b0});

    for (int m = 0; m < 2; m++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          step(4'(a), 4'(b), 1'(m), 1'b0);
          check($sformatf("sweep_m%0d_a%0d_b%0d", m, a, b), {S, C, V},
                model(4'(a), 4'(b), 1'(m)));
          if (m == 1 && a == 8 && b == 7) begin
            step(4'(a), 4'(b), 1'(m), 1'b1);
            check("mid_sweep_reset", {S, C, V}, {4'd0, 1'b0, 1'b0});
          end
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
